rpn_add_sequencer: RTL
======================

// Module: rpn_add_sequencer
// PURPOSE
//  RPN operand-stack controller for the ALU's add/subtract path. Accepts PUSH/ADD/SUB/CLR
//  commands, keeps a small LIFO operand stack and sequences one shared 4-bit adder
//  (somador4x4) nibble-serially to add/subtract the top two entries. The result
//  replaces those two entries. Sits between the front-end command decoder and the display/flags logic.
// PARAMETERS
//  WIDTH  8  operand width; must be a multiple of 4; NIB = WIDTH/4 adder passes per op
//  DEPTH  4  stack entries; DEPTH >= 2
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  cmd_valid      in   1      command present
//  cmd_ready      out  1      1 only in IDLE; transfer when cmd_valid & cmd_ready
//  cmd_op         in   2      00 PUSH, 01 ADD, 10 SUB, 11 CLR
//  cmd_data       in   WIDTH  operand for PUSH; ignored otherwise
//  top            out  WIDTH  stack[depth-1]; 0 when depth==0
//  depth          out  clog2(DEPTH+1)  current entry count
//  busy           out  1      1 while an ADD/SUB is in flight
//  done           out  1      1-cycle pulse when any accepted command completes
//  carry_flag     out  1      carry out of last ADD/SUB (SUB: 1 = no borrow)
//  ovf_flag       out  1      signed overflow of last ADD/SUB
//  err_underflow  out  1      1-cycle pulse: ADD/SUB accepted with depth<2
//  err_overflow   out  1      1-cycle pulse: PUSH accepted with depth==DEPTH
// BEHAVIOUR
//  Reset: stack entries, depth, flags, busy, done, errs = 0; state IDLE; cmd_ready = 1 next cycle.
//  rst wins over everything and aborts an in-flight op; no partial writeback.
//  States: IDLE -> EXEC (NIB cycles) -> WB -> IDLE.
//  PUSH (IDLE): if depth<DEPTH, write cmd_data at stack[depth], depth+1; done next cycle.
//   If depth==DEPTH: no change, err_overflow + done pulse next cycle.
//  CLR: depth=0 (entries need not be cleared), flags unchanged, done next cycle.
//  ADD/SUB with depth<2: no change, err_underflow + done pulse next cycle, stays IDLE.
//  ADD/SUB with depth>=2: latch A=stack[depth-2], B=stack[depth-1] (SUB: B inverted),
//   go to EXEC with nibble index k=0, and set busy.
//   EXEC cycle k: adder A=A[4k+3:4k], B=B'[4k+3:4k], Cin = (k==0) ? is_sub : carry_reg;
//   store S into res[4k+3:4k]; carry_reg <= Co; after k==NIB-1 -> WB.
//   WB: stack[depth-2]=res, depth-1, carry_flag=carry_reg,
//   ovf_flag = (A[MSB]==B'[MSB]) & (res[MSB]!=A[MSB]); done pulse; busy=0; -> IDLE.
//  Latency: accept at edge t -> done high in cycle t+NIB+1 (8-bit: 3 cycles after accept).
//  Results wrap modulo 2^WIDTH. No further command is accepted until back in IDLE.
//  cmd_valid while busy: ignored (cmd_ready=0); the command is held by the sender.
//  Back-to-back: a new command may be accepted in the first IDLE cycle after done.
//  err_* pulses never coincide with a stack or flag change.
// STRUCTURE
//  Include file rpn_defs.vh: opcode constants (OP_PUSH/ADD/SUB/CLR) and state encodings.
//  One sub-module: a single somador4x4 instance, time-shared across nibbles; no other adder.
//  Stack is a register array, indexed by depth; no RAM inference required.
// TESTING
//  1 PUSH 0x3C, PUSH 0x45, ADD -> top=0x81, depth=1, carry=0, ovf=1, done 3 cycles after ADD accept.
//  2 PUSH 0x10, PUSH 0x20, SUB -> top=0xF0, carry=0, ovf=0; PUSH 0xFF, PUSH 0x01, ADD -> top=0x00, carry=1.
//  3 PUSH 0x80, PUSH 0x01, SUB -> top=0x7F, carry=1, ovf=1 (signed overflow on subtract).
//  4 After CLR, PUSH 0x07, ADD -> err_underflow pulse, depth=1, top=0x07; 5 PUSHes -> err_overflow on 5th, depth=4.
//  5 rst asserted in the EXEC cycle after ADD -> next cycle depth=0, top=0, busy=0, no done pulse.
//  6 cmd_valid held high during busy with PUSH 0x55 -> not taken until IDLE; then accepted once, depth+1.

Source files
------------

// File: rtl/rpn_add_sequencer_pkg.sv
// rpn_add_sequencer_pkg: shared opcode and FSM state encodings
// for the RPN add/subtract stack controller.
package rpn_add_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

endpackage

// File: rtl/rpn_add_sequencer_somador4x4.sv
// somador4x4: 4-bit ripple adder with carry in/out, shared
// across nibbles. Ports: a_i, b_i, ci_i -> s_o, co_o.
module rpn_add_sequencer_somador4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0, ci_i};

endmodule

// File: rtl/rpn_add_sequencer.sv
// rpn_add_sequencer: LIFO operand stack with nibble-serial
// add/sub through one 4-bit adder. Ports: cmd_* handshake in;
// top/depth/flags/done/err_* status out; busy while in flight.
module rpn_add_sequencer
  import rpn_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       done,
  output logic                       carry_flag,
  output logic                       ovf_flag,
  output logic                       err_underflow,
  output logic                       err_overflow
);

  localparam int NIB = WIDTH / 4;
  localparam int DW  = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [KW-1:0]    k_q;
  logic             is_sub_q, carry_q;
  logic             cflag_q, oflag_q;
  logic             done_q, eund_q, eovf_q;

  logic             accept, full, short, last;
  logic [KW+1:0]    sh;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_ci, nib_co;

  assign accept = cmd_valid & cmd_ready;
  assign full   = (depth_q == DW'(DEPTH));
  assign short  = (depth_q < DW'(2));
  assign last   = (k_q == KW'(NIB - 1));

  // bit offset of the nibble being processed this cycle
  assign sh     = {k_q, 2'b00};
  assign nib_a  = 4'(a_q >> sh);
  assign nib_b  = 4'(b_q >> sh);
  assign nib_ci = (k_q == '0) ? is_sub_q : carry_q;

  rpn_add_sequencer_somador4x4 u_add (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .ci_i (nib_ci),
    .s_o  (nib_s),
    .co_o (nib_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !short &&
            (op_e'(cmd_op) == OP_ADD ||
             op_e'(cmd_op) == OP_SUB))
          state_d = ST_EXEC;
      end
      ST_EXEC: if (last) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      depth_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      k_q      <= '0;
      is_sub_q <= 1'b0;
      carry_q  <= 1'b0;
      cflag_q  <= 1'b0;
      oflag_q  <= 1'b0;
      done_q   <= 1'b0;
      eund_q   <= 1'b0;
      eovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      eund_q <= 1'b0;
      eovf_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            unique case (op_e'(cmd_op))
              OP_PUSH: begin
                done_q <= 1'b1;
                if (full) begin
                  eovf_q <= 1'b1;
                end else begin
                  stack_q[AW'(depth_q)] <= cmd_data;
                  depth_q <= depth_q + DW'(1);
                end
              end
              OP_CLR: begin
                done_q  <= 1'b1;
                depth_q <= '0;
              end
              OP_ADD, OP_SUB: begin
                if (short) begin
                  done_q <= 1'b1;
                  eund_q <= 1'b1;
                end else begin
                  // SUB = A + ~B + 1; the +1 enters as nibble-0 carry
                  a_q <= stack_q[AW'(depth_q - DW'(2))];
                  b_q <= stack_q[AW'(depth_q - DW'(1))]
                         ^ {WIDTH{op_e'(cmd_op) == OP_SUB}};
                  is_sub_q <= (op_e'(cmd_op) == OP_SUB);
                  k_q      <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        ST_EXEC: begin
          res_q <= (res_q & ~(WIDTH'(4'hF) << sh))
                 | (WIDTH'(nib_s) << sh);
          carry_q <= nib_co;
          k_q     <= k_q + KW'(1);
        end
        ST_WB: begin
          stack_q[AW'(depth_q - DW'(2))] <= res_q;
          depth_q <= depth_q - DW'(1);
          cflag_q <= carry_q;
          oflag_q <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                   & (res_q[WIDTH-1] != a_q[WIDTH-1]);
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign top = (depth_q == '0) ? '0
             : stack_q[AW'(depth_q - DW'(1))];
  assign depth         = depth_q;
  assign done          = done_q;
  assign carry_flag    = cflag_q;
  assign ovf_flag      = oflag_q;
  assign err_underflow = eund_q;
  assign err_overflow  = eovf_q;

endmodule
